// File: rtl/tristate_bus_arbiter_pkg.sv
// rtl/tristate_bus_arbiter_pkg.sv - shared state encodings and sizing helper for the bus arbiter
package tristate_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TURN  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        TURN  = ST_TURN,
        DRIVE = ST_DRIVE
    } arb_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rtl/tristate_bus_arbiter_rr_pick.sv - combinational round-robin selector
module tristate_bus_arbiter_rr_pick
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PTR_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    // Walk from farthest to nearest so the first set bit after ptr is the last write.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int k = N_CH; k >= 1; k--) begin
            int j;
            j = (int'(ptr) + k) % N_CH;
            if (req[j]) begin
                idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner of a shared tri-state bus with turnaround and burst limit
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [N_CH-1:0]       gnt,
    inout  wire  [WIDTH-1:0]      bus,
    output logic                  bus_oe,
    output logic [WIDTH-1:0]      bus_in,
    output logic                  busy
);

    localparam int PTR_W  = clog2_min1(N_CH);
    localparam int BEAT_W = clog2_min1(MAX_BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(N_CH - 1);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic              bus_oe_q, bus_oe_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  bus_in_q, bus_in_d;

    logic [N_CH-1:0]   own_mask;
    logic [WIDTH-1:0]  drive_data;
    logic              own_req;
    logic              others;
    logic [PTR_W-1:0]  pick_ptr;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_found;

    always_comb begin
        own_mask   = '0;
        drive_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_mask[i] = 1'b1;
                drive_data  = din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign own_req = |(req & own_mask);
    assign others  = |(req & ~own_mask);

    // On release the outgoing owner becomes the pointer, so it drops to lowest priority.
    assign pick_ptr = (state_q == DRIVE) ? owner_q : rr_ptr_q;

    tristate_bus_arbiter_rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        gnt_d    = '0;
        bus_oe_d = 1'b0;
        bus_in_d = bus;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = TURN;
                    owner_d = pick_idx;
                end
            end
            TURN: begin
                if (own_req) begin
                    state_d  = DRIVE;
                    gnt_d    = own_mask;
                    bus_oe_d = 1'b1;
                    beat_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (own_req && ((beat_q < LAST_BEAT) || !others)) begin
                    gnt_d    = own_mask;
                    bus_oe_d = 1'b1;
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    rr_ptr_d = owner_q;
                    if (others) begin
                        state_d = TURN;
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= PTR_INIT;
            beat_q   <= '0;
            gnt_q    <= '0;
            bus_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            bus_in_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
            bus_oe_q <= bus_oe_d;
            busy_q   <= busy_d;
            bus_in_q <= bus_in_d;
        end
    end

    assign bus    = bus_oe_q ? drive_data : {WIDTH{1'bz}};
    assign gnt    = gnt_q;
    assign bus_oe = bus_oe_q;
    assign busy   = busy_q;
    assign bus_in = bus_in_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - directed self-checking bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH-1:0]       req = '0;
    logic [N_CH*WIDTH-1:0] din;
    logic [N_CH-1:0]       gnt;
    wire  [WIDTH-1:0]      bus;
    logic                  bus_oe;
    logic [WIDTH-1:0]      bus_in;
    logic                  busy;
    logic                  tb_oe = 1'b0;
    logic [WIDTH-1:0]      tb_drv = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ch_data [N_CH];
    int         order   [5];

    assign bus = tb_oe ? tb_drv : {WIDTH{1'bz}};

    tristate_bus_arbiter #(
        .N_CH      (N_CH),
        .WIDTH     (WIDTH),
        .MAX_BURST (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
        .gnt    (gnt),
        .bus    (bus),
        .bus_oe (bus_oe),
        .bus_in (bus_in),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inv(input string tag);
        chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
        chk({tag, "_oe_eq_gnt"}, 32'(bus_oe), 32'(|gnt));
    endtask

    initial begin
        ch_data[0] = 8'h3C;
        ch_data[1] = 8'hA5;
        ch_data[2] = 8'hC3;
        ch_data[3] = 8'h7E;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        din = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

        // reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_oe", 32'(bus_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bus_in", 32'(bus_in), 32'h0);
        rst_n = 1'b1;

        // single request on ch0
        req = 4'b0001;
        tick();
        chk("single_turn_gnt", 32'(gnt), 32'h0);
        chk("single_turn_oe", 32'(bus_oe), 32'h0);
        chk("single_turn_busy", 32'(busy), 32'h1);
        tick();
        chk("single_drive_gnt", 32'(gnt), 32'h1);
        chk("single_drive_oe", 32'(bus_oe), 32'h1);
        chk("single_drive_bus", 32'(bus), 32'h3C);
        tick();
        chk("single_bus_in", 32'(bus_in), 32'h3C);
        req = 4'b0000;
        tick();
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_oe", 32'(bus_oe), 32'h0);
        chk("single_rel_busy", 32'(busy), 32'h0);

        // request withdrawn during TURN
        req = 4'b0010;
        tick();
        chk("wd_turn_busy", 32'(busy), 32'h1);
        chk("wd_turn_oe", 32'(bus_oe), 32'h0);
        req = 4'b0000;
        tick();
        chk("wd_idle_gnt", 32'(gnt), 32'h0);
        chk("wd_idle_busy", 32'(busy), 32'h0);
        tick();
        chk("wd_idle_oe", 32'(bus_oe), 32'h0);

        // external traffic while the block is not driving
        tb_drv = 8'h5A;
        tb_oe  = 1'b1;
        #1;
        chk("ext_bus", 32'(bus), 32'h5A);
        tick();
        chk("ext_bus_in", 32'(bus_in), 32'h5A);
        tb_oe = 1'b0;

        // full contention from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("cont%0d_turn_gnt", g), 32'(gnt), 32'h0);
            chk($sformatf("cont%0d_turn_oe", g), 32'(bus_oe), 32'h0);
            chk($sformatf("cont%0d_turn_busy", g), 32'(busy), 32'h1);
            for (int b = 0; b < 4; b++) begin
                tick();
                chk($sformatf("cont%0d_b%0d_gnt", g, b), 32'(gnt), 32'(1 << order[g]));
                chk($sformatf("cont%0d_b%0d_bus", g, b), 32'(bus), 32'(ch_data[order[g]]));
                chk_inv($sformatf("cont%0d_b%0d", g, b));
            end
        end
        req = 4'b0000;
        tick();
        chk("cont_end_gnt", 32'(gnt), 32'h0);
        chk("cont_end_busy", 32'(busy), 32'h0);

        // lone requester is never forced off
        req = 4'b0100;
        tick();
        chk("lone_turn_gnt", 32'(gnt), 32'h0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("lone_c%0d_gnt", c), 32'(gnt), 32'h4);
            chk($sformatf("lone_c%0d_bus", c), 32'(bus), 32'hC3);
        end
        req = 4'b0000;
        tick();
        chk("lone_rel_gnt", 32'(gnt), 32'h0);

        // reset asserted while ch1 drives
        req = 4'b0010;
        tick();
        tick();
        chk("rmd_drive_gnt", 32'(gnt), 32'h2);
        chk("rmd_drive_bus", 32'(bus), 32'hA5);
        rst_n = 1'b0;
        #1;
        chk("rmd_async_gnt", 32'(gnt), 32'h0);
        chk("rmd_async_oe", 32'(bus_oe), 32'h0);
        chk("rmd_async_busy", 32'(busy), 32'h0);
        tick();
        chk("rmd_hold_gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rmd_turn_gnt", 32'(gnt), 32'h0);
        chk("rmd_turn_busy", 32'(busy), 32'h1);
        tick();
        chk("rmd_regrant_gnt", 32'(gnt), 32'h2);
        chk("rmd_regrant_bus", 32'(bus), 32'hA5);
        req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
